pipe_ctrl: RTL

Central stall/flush controller for the five-stage integer pipeline. It collects per-stage stall requests and the MEM-stage exception request, and drives the `stall_current_stage` / `stall_next_stage` pairs of every pipeline register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB). It also drives the pipeline flush and PC redirect. It sits beside the datapath in the CPU top level and is the only source of stall and flush control.

---
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the five-stage pipeline: stall vector, flush and PC redirect.
// Optional stall watchdog enabled by defining PIPE_STALL_WDT_EN.
module pipe_ctrl #(
  parameter int WDT_LIMIT = 1023,
  parameter int WDT_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  stall_req_i,
  input  logic        exc_req_i,
  input  logic [31:0] exc_pc_i,
  output logic [4:0]  stall_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        wdt_timeout_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [4:0]  stall_s;
  logic        flush_s;
  logic        redirect_valid_s;
  logic        exc_take_s;
  logic [31:0] redirect_pc_r;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next state and stall/flush decode
  always_comb begin
    state_nxt_s      = state_r;
    stall_s          = 5'b00000;
    flush_s          = 1'b0;
    redirect_valid_s = 1'b0;
    exc_take_s       = 1'b0;
    case (state_r)
      RUN: begin
        if (exc_req_i) begin
          // freeze everything so the excepting instruction cannot commit
          stall_s    = 5'b11111;
          exc_take_s = 1'b1;
          if (stall_req_i[3]) begin
            state_nxt_s = WAIT_MEM;
          end else begin
            state_nxt_s = FLUSH;
          end
        end else begin
          casez (stall_req_i)
            4'b1???: stall_s = 5'b01111;
            4'b01??: stall_s = 5'b00111;
            4'b001?: stall_s = 5'b00011;
            4'b0001: stall_s = 5'b00001;
            default: stall_s = 5'b00000;
          endcase
        end
      end
      WAIT_MEM: begin
        stall_s = 5'b11111;
        if (stall_req_i[3]) begin
          state_nxt_s = WAIT_MEM;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      FLUSH: begin
        flush_s          = 1'b1;
        redirect_valid_s = 1'b1;
        state_nxt_s      = RUN;
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // stall vector is forced low while reset is held, independent of requests
  always_comb begin
    if (!rst) begin
      stall_o = 5'b00000;
    end else begin
      stall_o = stall_s;
    end
  end

  assign flush_o          = flush_s;
  assign redirect_valid_o = redirect_valid_s;
  assign redirect_pc_o    = redirect_pc_r;

  // handler address capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_pc_r <= 32'h0000_0000;
    end else if (exc_take_s) begin
      redirect_pc_r <= exc_pc_i;
    end else begin
      redirect_pc_r <= redirect_pc_r;
    end
  end

`ifdef PIPE_STALL_WDT_EN
  localparam logic [WDT_WIDTH-1:0] WDT_MAX = WDT_WIDTH'(WDT_LIMIT);

  logic [WDT_WIDTH-1:0] wdt_cnt_r;
  logic [WDT_WIDTH-1:0] wdt_cnt_nxt_s;
  logic                 wdt_flag_r;

  // saturating count of consecutive stalled fetch cycles
  always_comb begin
    if (!stall_o[0]) begin
      wdt_cnt_nxt_s = {WDT_WIDTH{1'b0}};
    end else if (wdt_cnt_r == WDT_MAX) begin
      wdt_cnt_nxt_s = wdt_cnt_r;
    end else begin
      wdt_cnt_nxt_s = wdt_cnt_r + {{(WDT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // watchdog counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_cnt_r  <= {WDT_WIDTH{1'b0}};
      wdt_flag_r <= 1'b0;
    end else begin
      wdt_cnt_r  <= wdt_cnt_nxt_s;
      wdt_flag_r <= wdt_flag_r | (wdt_cnt_nxt_s == WDT_MAX);
    end
  end

  assign wdt_timeout_o = wdt_flag_r;
`else
  logic [WDT_WIDTH-1:0] wdt_unused_s;
  assign wdt_unused_s  = WDT_WIDTH'(WDT_LIMIT);
  assign wdt_timeout_o = 1'b0;
`endif

endmodule
